// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulo-M up/down counter with a shadowed modulus that is applied only at wrap or clear.
// Optional square-wave output sqw is compiled in when PROG_COUNTER_SQW_EN is defined.
module prog_mod_counter #(
  parameter int N         = 16,
  parameter int M_DEFAULT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         dir,
  input  logic         m_load,
  input  logic [N-1:0] m_in,
  output logic [N-1:0] q,
  output logic [N-1:0] m_cur,
  output logic         tc,
  output logic         max_tick,
  output logic         m_pend,
  output logic         m_err
`ifdef PROG_COUNTER_SQW_EN
  ,
  output logic         sqw
`endif
);

  localparam logic [N-1:0] ZERO  = {N{1'b0}};
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] M_RST = N'(M_DEFAULT);

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] m_cur_q, m_cur_d;
  logic [N-1:0] pend_val_q, pend_val_d;
  logic         m_pend_q, m_pend_d;
  logic         m_err_q, m_err_d;

  logic [N-1:0] max_val_s;
  logic [N-1:0] term_s;
  logic [N-1:0] m_next_s;
  logic [N-1:0] m_next_max_s;
  logic         at_term_s;
  logic         wrap_s;

  // Terminal detection and the modulus that takes effect at the next wrap/clear
  always_comb begin
    max_val_s    = m_cur_q - ONE;
    term_s       = dir ? max_val_s : ZERO;
    at_term_s    = (q_q == term_s);
    wrap_s       = en & at_term_s;
    m_next_s     = m_pend_q ? pend_val_q : m_cur_q;
    m_next_max_s = m_next_s - ONE;
  end

  // Next-state for count, active modulus and the pending-modulus shadow
  always_comb begin
    q_d        = q_q;
    m_cur_d    = m_cur_q;
    pend_val_d = pend_val_q;
    m_pend_d   = m_pend_q;
    m_err_d    = 1'b0;

    // Wrap and clear both reload q relative to the modulus being applied
    if (clr || wrap_s) begin
      m_cur_d  = m_next_s;
      m_pend_d = 1'b0;
      q_d      = dir ? ZERO : m_next_max_s;
    end else if (en) begin
      q_d = dir ? (q_q + ONE) : (q_q - ONE);
    end else begin
      q_d = q_q;
    end

    // A load on an applying edge lands in the shadow for the following wrap
    if (m_load) begin
      if (m_in != ZERO) begin
        pend_val_d = m_in;
        m_pend_d   = 1'b1;
      end else begin
        m_err_d = 1'b1;
      end
    end else begin
      m_err_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= ZERO;
      m_cur_q    <= M_RST;
      pend_val_q <= ZERO;
      m_pend_q   <= 1'b0;
      m_err_q    <= 1'b0;
    end else begin
      q_q        <= q_d;
      m_cur_q    <= m_cur_d;
      pend_val_q <= pend_val_d;
      m_pend_q   <= m_pend_d;
      m_err_q    <= m_err_d;
    end
  end

  assign q        = q_q;
  assign m_cur    = m_cur_q;
  assign m_pend   = m_pend_q;
  assign m_err    = m_err_q;
  assign max_tick = (q_q == max_val_s);
  assign tc       = wrap_s & ~clr & ~rst;

`ifdef PROG_COUNTER_SQW_EN
  logic sqw_q, sqw_d;

  // Square wave toggles once per terminal-count tick
  always_comb begin
    if (clr) begin
      sqw_d = 1'b0;
    end else if (tc) begin
      sqw_d = ~sqw_q;
    end else begin
      sqw_d = sqw_q;
    end
  end

  // Square-wave register
  always_ff @(posedge clk) begin
    if (rst) begin
      sqw_q <= 1'b0;
    end else begin
      sqw_q <= sqw_d;
    end
  end

  assign sqw = sqw_q;
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed self-checking bench for prog_mod_counter (N=16, M_DEFAULT=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_prog_mod_counter;

  logic        clk = 1'b0;
  logic        rst, en, clr, dir, m_load;
  logic [15:0] m_in;
  logic [15:0] q, m_cur;
  logic        tc, max_tick, m_pend, m_err;
`ifdef PROG_COUNTER_SQW_EN
  logic        sqw;
  logic        exp_sqw;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  prog_mod_counter #(.N(16), .M_DEFAULT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .dir(dir),
    .m_load(m_load), .m_in(m_in),
    .q(q), .m_cur(m_cur), .tc(tc), .max_tick(max_tick),
    .m_pend(m_pend), .m_err(m_err)
`ifdef PROG_COUNTER_SQW_EN
    , .sqw(sqw)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; dir = 1'b1; m_load = 1'b0; m_in = 16'd0;
    cyc();
    settle();
    check("rst_q", q, 0);
    check("rst_mcur", m_cur, 3);
    check("rst_mpend", m_pend, 0);
    check("rst_merr", m_err, 0);
    check("rst_tc", tc, 0);

    // Up count with default modulus 3
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      check("up_q", q, i % 3);
      check("up_tc", tc, (i % 3) == 2);
      check("up_max", max_tick, (i % 3) == 2);
      cyc();
    end

    // Load 5, clear while counting down -> start at 4
    m_load = 1'b1; m_in = 16'd5;
    cyc();
    m_load = 1'b0; clr = 1'b1; dir = 1'b0;
    settle();
    check("dn_pend_before_clr", m_pend, 1);
    cyc();
    clr = 1'b0;
    settle();
    check("dn_mcur", m_cur, 5);
    check("dn_mpend", m_pend, 0);
    check("dn_max_indep_dir", max_tick, 1);
    check("dn_tc_at_top", tc, 0);
    for (int i = 0; i < 6; i++) begin
      settle();
      check("dn_q", q, (i == 5) ? 4 : 4 - i);
      check("dn_tc", tc, i == 4);
      cyc();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("hold_q", q, 3);
      check("hold_tc", tc, 0);
      cyc();
    end
    en = 1'b1;

    // Shadow reload: m_cur 10, load 4 at q=2, applied at wrap
    m_load = 1'b1; m_in = 16'd10;
    cyc();
    m_load = 1'b0; clr = 1'b1; dir = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_load = (i == 2); m_in = 16'd4;
      settle();
      check("sh_q", q, i);
      check("sh_mcur", m_cur, 10);
      check("sh_mpend", m_pend, i >= 3);
      check("sh_tc", tc, i == 9);
      cyc();
    end
    m_load = 1'b0;
    settle();
    check("sh_wrap_q", q, 0);
    check("sh_wrap_mcur", m_cur, 4);
    check("sh_wrap_mpend", m_pend, 0);

    // Collision: pending 8, load 6 on the wrap edge
    m_load = 1'b1; m_in = 16'd8;
    cyc();
    m_load = 1'b0;
    cyc();
    settle();
    check("col_q2", q, 2);
    check("col_mcur4", m_cur, 4);
    check("col_pend", m_pend, 1);
    cyc();
    m_load = 1'b1; m_in = 16'd6;
    settle();
    check("col_tc", tc, 1);
    cyc();
    m_load = 1'b0;
    settle();
    check("col_q0", q, 0);
    check("col_mcur8", m_cur, 8);
    check("col_pend_kept", m_pend, 1);
    for (int i = 0; i < 8; i++) begin
      settle();
      check("col_run_q", q, i);
      check("col_run_mcur", m_cur, 8);
      cyc();
    end
    settle();
    check("col2_q", q, 0);
    check("col2_mcur6", m_cur, 6);
    check("col2_mpend", m_pend, 0);

    // Illegal zero load, then modulus 1 via clear
    m_load = 1'b1; m_in = 16'd1;
    cyc();
    m_in = 16'd0;
    cyc();
    m_load = 1'b0;
    settle();
    check("ill_merr", m_err, 1);
    check("ill_pend_kept", m_pend, 1);
    cyc();
    settle();
    check("ill_merr_clear", m_err, 0);
    clr = 1'b1; dir = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("m1_q", q, 0);
      check("m1_mcur", m_cur, 1);
      check("m1_tc", tc, 1);
      check("m1_max", max_tick, 1);
      cyc();
    end
    en = 1'b0;
    settle();
    check("m1_tc_en0", tc, 0);
    en = 1'b1;

    // Clear mid-op down with pending 12
    m_load = 1'b1; m_in = 16'd9;
    cyc();
    m_load = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0; m_load = 1'b1; m_in = 16'd12;
    cyc();
    m_load = 1'b0;
    repeat (6) cyc();
    settle();
    check("cm_q7", q, 7);
    check("cm_mcur9", m_cur, 9);
    check("cm_pend", m_pend, 1);
    clr = 1'b1; dir = 1'b0;
    cyc();
    clr = 1'b0;
    settle();
    check("cm_q11", q, 11);
    check("cm_mcur12", m_cur, 12);
    check("cm_mpend0", m_pend, 0);

    // Down wrap reloads with the newly applied modulus
    m_load = 1'b1; m_in = 16'd7;
    cyc();
    m_load = 1'b0;
    repeat (10) cyc();
    settle();
    check("dw_q0", q, 0);
    check("dw_tc", tc, 1);
    cyc();
    settle();
    check("dw_q6", q, 6);
    check("dw_mcur7", m_cur, 7);

    // Reset with a pending modulus
    m_load = 1'b1; m_in = 16'd5;
    cyc();
    m_load = 1'b0;
    settle();
    check("rp_pend", m_pend, 1);
    rst = 1'b1;
    cyc();
    settle();
    check("rp_mcur", m_cur, 3);
    check("rp_mpend", m_pend, 0);
    check("rp_q", q, 0);
    check("rp_tc_in_rst", tc, 0);
    rst = 1'b0; dir = 1'b1;

`ifdef PROG_COUNTER_SQW_EN
    // Square wave: period 6 cycles for m_cur=3
    exp_sqw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      settle();
      check("sqw", sqw, exp_sqw);
      if ((i % 3) == 2) exp_sqw = ~exp_sqw;
      cyc();
    end
    repeat (3) cyc();
    settle();
    check("sqw_high", sqw, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    settle();
    check("sqw_clr", sqw, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
